// File: rtl/histogram_accumulator.sv
// Builds a 256-bin intensity histogram of one frame in an external RAM:
// a clear pass, then a read-modify-write pipeline with write-data forwarding.
module histogram_accumulator #(
  parameter int word_size = 20
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iStart,
  input  logic [7:0]           iPixel,
  input  logic                 iPixelValid,
  input  logic                 iFrameEnd,
  output logic [7:0]           oAddrRd,
  input  logic [word_size-1:0] iQRd,
  output logic [7:0]           oAddrWr,
  output logic [word_size-1:0] oDataWr,
  output logic                 oWE,
  output logic                 oBusy,
  output logic [word_size-1:0] oPixelCount,
  output logic                 oDone
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;

  localparam logic [word_size-1:0] COUNT_MAX = '1;

  state_t               state;
  state_t               state_next;
  logic                 a_valid;
  logic                 prev_we;
  logic [7:0]           prev_addr;
  logic [word_size-1:0] prev_data;
  logic                 accept;
  logic [word_size-1:0] base;
  logic [word_size-1:0] incremented;

  // iStart overrides everything, so a pixel in the same cycle is never taken.
  assign accept = iPixelValid && (state == ACCUM) && !iStart;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    oBusy      = 1'b0;
    oDone      = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) state_next = CLEAR;
      end
      CLEAR: begin
        oBusy = 1'b1;
        if (iStart)                  state_next = CLEAR;
        else if (oAddrWr == 8'hFF)   state_next = ACCUM;
      end
      ACCUM: begin
        oBusy = 1'b1;
        if (iStart)         state_next = CLEAR;
        else if (iFrameEnd) state_next = DRAIN;
      end
      DRAIN: begin
        oBusy = 1'b1;
        // Once stage A is empty, the last stage-B write lands on this edge.
        if (iStart)        state_next = CLEAR;
        else if (!a_valid) state_next = DONE;
      end
      DONE: begin
        oDone      = 1'b1;
        state_next = iStart ? CLEAR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage A: the registered read address doubles as the bin held in flight.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      a_valid <= 1'b0;
      oAddrRd <= '0;
    end else begin
      a_valid <= accept;
      if (accept) oAddrRd <= iPixel;
    end
  end

  // RAM still returns stale data for the write landing now and the one before.
  always_comb begin
    if (oWE && (oAddrWr == oAddrRd))             base = oDataWr;
    else if (prev_we && (prev_addr == oAddrRd))  base = prev_data;
    else                                         base = iQRd;
    incremented = (base == COUNT_MAX) ? base : base + word_size'(1);
  end

  // Stage B write register, shared by the clear sweep and the accumulation.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oWE     <= 1'b0;
      oAddrWr <= '0;
      oDataWr <= '0;
    end else if (iStart) begin
      oWE     <= 1'b1;
      oAddrWr <= '0;
      oDataWr <= '0;
    end else if ((state == CLEAR) && (oAddrWr != 8'hFF)) begin
      oWE     <= 1'b1;
      oAddrWr <= oAddrWr + 8'd1;
      oDataWr <= '0;
    end else if (a_valid) begin
      oWE     <= 1'b1;
      oAddrWr <= oAddrRd;
      oDataWr <= incremented;
    end else begin
      oWE     <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      prev_we   <= 1'b0;
      prev_addr <= '0;
      prev_data <= '0;
    end else begin
      prev_we   <= oWE;
      prev_addr <= oAddrWr;
      prev_data <= oDataWr;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oPixelCount <= '0;
    end else if (iStart) begin
      oPixelCount <= '0;
    end else if (accept && (oPixelCount != COUNT_MAX)) begin
      oPixelCount <= oPixelCount + word_size'(1);
    end
  end

endmodule

// File: tb/tb_histogram_accumulator.sv
// Directed bench: two instances (20-bit and 4-bit bins) share all stimulus,
// each backed by its own behavioural histogram RAM.
`timescale 1ns/1ps
module tb_histogram_accumulator;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iStart;
  logic [7:0]  iPixel;
  logic        iPixelValid;
  logic        iFrameEnd;

  logic [7:0]  addr_rd;
  logic [19:0] q;
  logic [7:0]  addr_wr;
  logic [19:0] data_wr;
  logic        we;
  logic        busy;
  logic [19:0] pix_count;
  logic        done;

  logic [7:0]  addr_rd_4;
  logic [3:0]  q_4;
  logic [7:0]  addr_wr_4;
  logic [3:0]  data_wr_4;
  logic        we_4;
  logic        busy_4;
  logic [3:0]  pix_count_4;
  logic        done_4;

  logic [19:0] ram   [256];
  logic [3:0]  ram_4 [256];
  logic [7:0]  hazard_pix [6];

  int vectors     = 0;
  int miscompares = 0;

  always #5 iClk = ~iClk;

  histogram_accumulator #(.word_size(20)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iPixel(iPixel),
    .iPixelValid(iPixelValid), .iFrameEnd(iFrameEnd), .oAddrRd(addr_rd),
    .iQRd(q), .oAddrWr(addr_wr), .oDataWr(data_wr), .oWE(we), .oBusy(busy),
    .oPixelCount(pix_count), .oDone(done)
  );

  histogram_accumulator #(.word_size(4)) dut_4 (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iPixel(iPixel),
    .iPixelValid(iPixelValid), .iFrameEnd(iFrameEnd), .oAddrRd(addr_rd_4),
    .iQRd(q_4), .oAddrWr(addr_wr_4), .oDataWr(data_wr_4), .oWE(we_4), .oBusy(busy_4),
    .oPixelCount(pix_count_4), .oDone(done_4)
  );

  // The read address is already registered inside the DUT, so data follows the
  // pixel by one cycle; a write landing on the coming edge is not yet visible.
  always @(posedge iClk) begin
    if (we)   ram[addr_wr]     <= data_wr;
    if (we_4) ram_4[addr_wr_4] <= data_wr_4;
  end
  assign q   = ram[addr_rd];
  assign q_4 = ram_4[addr_rd_4];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [7:0] pix, input logic valid, input logic fend);
    iStart      = start;
    iPixel      = pix;
    iPixelValid = valid;
    iFrameEnd   = fend;
    @(posedge iClk);
    #1;
  endtask

  // Issues iStart and follows the whole 256-cycle sweep, offering pixels that must be dropped.
  task automatic clearFrame(input string tag, input logic [7:0] pix, input logic valid, input logic fend);
    int bad = 0;
    applyStimulus(1'b1, pix, valid, fend);
    checkOutput({tag, "_count_zeroed"}, pix_count, 0);
    for (int i = 0; i < 256; i++) begin
      if (we !== 1'b1 || addr_wr !== 8'(i) || data_wr !== 20'd0 || busy !== 1'b1 || done !== 1'b0)
        bad++;
      applyStimulus(1'b0, 8'd200, 1'b1, 1'b0);
    end
    iPixelValid = 1'b0;
    checkOutput({tag, "_clear_bad_cycles"}, bad, 0);
    checkOutput({tag, "_accum_we"}, we, 0);
    checkOutput({tag, "_accum_busy"}, busy, 1);
  endtask

  task automatic runFrame(input logic [7:0] pix, input int n, input logic with_end);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, pix, 1'b1, with_end && (i == n - 1));
  endtask

  task automatic waitDone(input string tag, input int exp_k);
    int first = -1;
    int pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    end
    checkOutput({tag, "_done_at"}, first, exp_k);
    checkOutput({tag, "_done_pulses"}, pulses, 1);
    checkOutput({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic checkRam(input string tag, input int bin_a, input int exp_a, input int bin_b, input int exp_b);
    int stray = 0;
    checkOutput({tag, "_binA"}, ram[8'(bin_a)], exp_a);
    checkOutput({tag, "_binB"}, ram[8'(bin_b)], exp_b);
    for (int i = 0; i < 256; i++)
      if (i != bin_a && i != bin_b && ram[i] !== 20'd0) stray++;
    checkOutput({tag, "_stray_bins"}, stray, 0);
  endtask

  initial begin
    int off_bins;
    int idle_bad;
    hazard_pix = '{8'd3, 8'd3, 8'd5, 8'd3, 8'd5, 8'd5};
    iRst_n = 1'b1; iStart = 1'b0; iPixel = 8'd0; iPixelValid = 1'b0; iFrameEnd = 1'b0;
    #2 iRst_n = 1'b0;
    #1;
    checkOutput("rst_we", we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", pix_count, 0);
    checkOutput("rst_addr_rd", addr_rd, 0);
    checkOutput("rst_addr_wr", addr_wr, 0);
    checkOutput("rst_data_wr", data_wr, 0);
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);

    $display("[TB] frame of 1000 pixels of value 7");
    clearFrame("f7", 8'd9, 1'b1, 1'b0);
    runFrame(8'd7, 1000, 1'b1);
    checkOutput("f7_count", pix_count, 1000);
    waitDone("f7", 2);
    checkRam("f7", 7, 1000, 200, 0);

    $display("[TB] back-to-back hazard pattern 3,3,5,3,5,5");
    clearFrame("hz", 8'd0, 1'b0, 1'b0);
    checkRam("hz_cleared", 0, 0, 255, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, hazard_pix[i], 1'b1, i == 5);
    waitDone("hz", 2);
    checkOutput("hz_count", pix_count, 6);
    checkRam("hz", 3, 3, 5, 3);

    $display("[TB] ramp 0..255 four times, frame end on its own cycle");
    clearFrame("rp", 8'd0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 256; i++)
        applyStimulus(1'b0, 8'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    waitDone("rp", 1);
    off_bins = 0;
    for (int i = 0; i < 256; i++)
      if (ram[i] !== 20'd4) off_bins++;
    checkOutput("rp_off_bins", off_bins, 0);
    checkOutput("rp_bin0", ram[0], 4);
    checkOutput("rp_bin255", ram[255], 4);
    checkOutput("rp_count", pix_count, 1024);

    $display("[TB] 20 pixels of value 9 (saturates 4-bit bins)");
    clearFrame("sat", 8'd0, 1'b0, 1'b0);
    runFrame(8'd9, 20, 1'b1);
    waitDone("sat", 2);
    checkOutput("sat_ram9", ram[9], 20);
    checkOutput("sat_ram4_9", ram_4[9], 15);
    checkOutput("sat_count4", pix_count_4, 15);
    checkOutput("sat_count", pix_count, 20);

    $display("[TB] abort after 100 pixels, restart together with frame end");
    clearFrame("ab0", 8'd0, 1'b0, 1'b0);
    runFrame(8'd4, 100, 1'b0);
    checkOutput("ab_pre_count", pix_count, 100);
    clearFrame("ab1", 8'd4, 1'b1, 1'b1);
    checkOutput("ab_ram4_cleared", ram[4], 0);
    runFrame(8'd2, 50, 1'b1);
    waitDone("ab", 2);
    checkOutput("ab_count", pix_count, 50);
    checkRam("ab", 2, 50, 4, 0);

    $display("[TB] asynchronous reset in the middle of a frame");
    clearFrame("rm", 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 8'(i * 3 + 1), 1'b1, 1'b0);
    #2 iRst_n = 1'b0;
    #1;
    checkOutput("rm_we", we, 0);
    checkOutput("rm_busy", busy, 0);
    checkOutput("rm_count", pix_count, 0);
    checkOutput("rm_addr_rd", addr_rd, 0);
    checkOutput("rm_addr_wr", addr_wr, 0);
    checkOutput("rm_data_wr", data_wr, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    idle_bad = 0;
    applyStimulus(1'b0, 8'd5, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
      applyStimulus(1'b0, 8'd5, 1'b1, 1'b0);
    end
    checkOutput("rm_idle_bad_cycles", idle_bad, 0);
    checkOutput("rm_idle_count", pix_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/histogram_accumulator.md
Name: histogram_accumulator

Overview:
- Upstream stage of the cumulative-histogram / threshold block: builds a 256-bin intensity histogram of one frame into the histogram RAM, which the cumulative stage then reads.
- Clears the RAM, then increments one bin per valid 8-bit pixel through a read-modify-write pipeline with forwarding.
- Signals frame completion with a one-cycle oDone pulse, which the downstream stage uses as its start.

Parameters:
- word_size, 20, width of each bin count and of the pixel counter; 800*480 = 384000 fits.

Ports:
- iClk  in  1  clock.
- iRst_n  in  1  reset, asynchronous and active-low.
- iStart  in  1  pulse: clear the RAM and begin a new frame; honoured in any state.
- iPixel  in  8  pixel intensity (bin index).
- iPixelValid  in  1  iPixel is valid this cycle.
- iFrameEnd  in  1  pulse: last pixel of the frame has been presented (this cycle or earlier).
- oAddrRd  out  8  histogram RAM read address.
- iQRd  in  word_size  histogram RAM read data; one-cycle latency; returns old data on read-during-write.
- oAddrWr  out  8  RAM write address.
- oDataWr  out  word_size  RAM write data.
- oWE  out  1  RAM write enable.
- oBusy  out  1  high in the CLEAR, ACCUM and DRAIN states.
- oPixelCount  out  word_size  number of valid pixels accepted this frame; saturating.
- oDone  out  1  one-cycle pulse after the final write of the frame.

Behaviour:
- Reset (iRst_n low, asynchronous):
  - State is IDLE.
  - All outputs are 0: oAddrRd, oAddrWr, oDataWr, oWE, oBusy, oPixelCount, oDone.
  - Pipeline valid flags are 0.
- State IDLE:
  - Pixels are ignored; oWE = 0.
  - iStart moves to CLEAR.
- State CLEAR:
  - Writes 0 to addresses 0..255, one per cycle: oWE = 1, oAddrWr = clear counter, oDataWr = 0.
  - Lasts exactly 256 cycles, then moves to ACCUM.
  - oPixelCount is reset to 0 on entry.
  - Pixels arriving during CLEAR are dropped.
- State ACCUM, three-stage pipeline:
  - S0, cycle n: a valid pixel sets oAddrRd <= iPixel and records the valid flag and bin in stage A.
  - S1, cycle n+1: iQRd holds the count for the bin. The base value is chosen in priority order:
    - if the stage-B write register (being written this cycle) holds the same bin, use its data;
    - else if the previous write (one cycle earlier) holds the same bin, use that data;
    - else use iQRd.
  - S1 computes new = base + 1, saturating at 2^word_size - 1, and registers oAddrWr = bin, oDataWr = new, oWE = 1 (stage B).
  - The write occurs in cycle n+2. oWE = 0 in any cycle with no stage-B valid.
  - Latency from pixel to RAM write is 2 cycles. Throughput is one pixel per cycle, including runs of the same bin.
  - oPixelCount increments per accepted pixel, saturating.
  - iFrameEnd moves to DRAIN. A pixel valid in the same cycle is accepted and counted.
- State DRAIN:
  - New pixels are ignored.
  - Waits until stages A and B are empty (at most 2 cycles), then moves to DONE.
- State DONE:
  - oDone = 1 for exactly one cycle; oBusy = 0.
  - Moves to IDLE. oPixelCount holds until the next CLEAR.
- iStart in CLEAR, ACCUM or DRAIN:
  - Aborts the frame and flushes the pipeline valid flags (in-flight writes are discarded).
  - Restarts CLEAR from address 0 on the next cycle; no oDone is issued for the aborted frame.
- iStart together with iFrameEnd: iStart wins.
- iFrameEnd outside ACCUM: ignored.
- Bin index 255 requires no wrap logic; address widths are exactly 8 bits.

Test Plan:
- Reset mid-ACCUM → all outputs 0 immediately (asynchronous); after release the block is in IDLE and oWE stays 0 for 10 cycles.
- iStart → oWE high for 256 consecutive cycles with oAddrWr 0..255 and oDataWr = 0; model RAM reads all-zero afterwards.
- 1000 consecutive valid pixels of value 7 → RAM[7] = 1000, all other bins 0, oPixelCount = 1000; exactly one oDone two or three cycles after iFrameEnd.
- Alternating pattern 3,3,5,3,5,5 (back-to-back, forwarding hazards) → RAM[3] = 3, RAM[5] = 3.
- Ramp 0..255 repeated 1500 times (384000 pixels) → every bin = 1500, oPixelCount = 384000; with word_size = 4, 20 pixels of value 9 give RAM[9] = 15 (saturated).
- iStart issued 100 pixels into a frame → no oDone; a fresh 256-cycle CLEAR follows; the next 50-pixel frame of value 2 gives RAM[2] = 50 with nothing left over from the aborted frame.
